// File: rtl/rv32i_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_defs (package)
// Description : Shared RV32I definitions: opcode formats plus the state and
//               datapath-select encodings used by the multicycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_defs;

    // Major opcode field instr[6:0]
    typedef enum logic [6:0] {
        LOAD          = 7'b0000011,
        IMM_OPERATION = 7'b0010011,
        AUIPC         = 7'b0010111,
        STORE         = 7'b0100011,
        REG_OPERATION = 7'b0110011,
        LUI           = 7'b0110111,
        BRANCH        = 7'b1100011,
        JALR          = 7'b1100111,
        JAL           = 7'b1101111
    } opcode_fmt_t;

    // Multicycle controller states; encoding is visible on the debug port
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE_R = 4'd6,
        S_EXECUTE_I = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BEQ       = 4'd9,
        S_JAL       = 4'd10
    } mc_state_t;

    typedef enum logic {
        ADR_PC     = 1'b0,
        ADR_ALUOUT = 1'b1
    } adr_src_t;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_DATA   = 2'b01,
        RES_ALU    = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    // Immediate format implied by the opcode; unknown opcodes fall back to I
    function automatic imm_src_t imm_src_of(input logic [6:0] op);
        imm_src_t r;
        case (op)
            LOAD, IMM_OPERATION: r = IMM_I;
            STORE:               r = IMM_S;
            BRANCH:              r = IMM_B;
            JAL:                 r = IMM_J;
            default:             r = IMM_I;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_fsm
// Description : Multicycle controller state register, next-state logic and
//               per-state (Moore) output decode. Strobes that depend on
//               mem_ready/zero are qualified combinationally.
// Ports       : clk, rst_n          - clock, async active-low reset
//               opcode, zero,        - IR opcode, ALU zero flag,
//               mem_ready            - memory handshake
//               mem_req..illegal     - raw (ungated) control outputs
//               retire               - current cycle retires an instruction
//               state                - current state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module mc_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic       retire,
    output logic [3:0] state
);
    import rv32i_defs::*;

    mc_state_t r_state;
    mc_state_t w_next_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        adr_src      = ADR_PC;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        result_src   = RES_ALUOUT;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RS2;
        alu_op       = ALUOP_ADD;
        illegal      = 1'b0;
        retire       = 1'b0;

        case (r_state)
            S_FETCH: begin
                // PC+4 goes straight from the ALU onto the result bus
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // old_pc + imm is parked in ALU-out for BEQ
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    LOAD, STORE:   w_next_state = S_MEM_ADR;
                    REG_OPERATION: w_next_state = S_EXECUTE_R;
                    IMM_OPERATION: w_next_state = S_EXECUTE_I;
                    BRANCH:        w_next_state = S_BEQ;
                    JAL:           w_next_state = S_JAL;
                    default: begin
                        illegal      = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a    = SRCA_RS1;
                alu_src_b    = SRCB_IMM;
                w_next_state = (opcode == LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                adr_src = ADR_ALUOUT;
                if (mem_ready) begin
                    w_next_state = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                result_src   = RES_DATA;
                reg_write    = 1'b1;
                retire       = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = ADR_ALUOUT;
                if (mem_ready) begin
                    retire       = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_EXECUTE_R: begin
                alu_src_a    = SRCA_RS1;
                alu_src_b    = SRCB_RS2;
                alu_op       = ALUOP_FUNCT;
                w_next_state = S_ALU_WB;
            end
            S_EXECUTE_I: begin
                alu_src_a    = SRCA_RS1;
                alu_src_b    = SRCB_IMM;
                alu_op       = ALUOP_FUNCT;
                w_next_state = S_ALU_WB;
            end
            S_ALU_WB: begin
                result_src   = RES_ALUOUT;
                reg_write    = 1'b1;
                retire       = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                // PC <- target held in ALU-out; ALU forms old_pc+4 for rd
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALUOUT;
                pc_write     = 1'b1;
                w_next_state = S_ALU_WB;
            end
            S_BEQ: begin
                alu_src_a    = SRCA_RS1;
                alu_src_b    = SRCB_RS2;
                alu_op       = ALUOP_SUB;
                result_src   = RES_ALUOUT;
                pc_write     = zero;
                retire       = 1'b1;
                w_next_state = S_FETCH;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Control unit for the multicycle RV32I core. Wraps the FSM,
//               adds immediate-format decode, reset gating of the memory and
//               PC/IR strobes, and the retired-instruction counter.
// Ports       : clk, rst_n        - clock, async active-low reset
//               opcode, zero,      - IR opcode, ALU zero flag,
//               mem_ready          - memory completes request this cycle
//               mem_req..imm_src   - datapath selects and strobes
//               illegal            - unsupported opcode seen in DECODE
//               instret            - retired-instruction count (wraps)
//               state              - current state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           imm_src,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret,
    output logic [3:0]           state
);
    import rv32i_defs::*;

    logic                 w_mem_req;
    logic                 w_ir_write;
    logic                 w_pc_write;
    logic                 w_retire;
    logic [INSTRET_W-1:0] r_instret;

    mc_fsm u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (w_mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (w_ir_write),
        .pc_write   (w_pc_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .illegal    (illegal),
        .retire     (w_retire),
        .state      (state)
    );

    // The async reset already forces FETCH; only FETCH's request and its
    // ready-qualified IR/PC loads need masking so nothing fires in reset.
    assign mem_req  = w_mem_req  & rst_n;
    assign ir_write = w_ir_write & rst_n;
    assign pc_write = w_pc_write & rst_n;

    assign imm_src = rst_n ? imm_src_of(opcode) : IMM_I;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + INSTRET_W'(1);
        end
    end

    assign instret = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Self-checking bench for multicycle_controller. Table vectors,
//               reset/wrap sequences and randomized instruction streams are
//               compared against a per-instruction phase model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    localparam int C_W = 4;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEM_ADR = 2, P_MEM_READ = 3,
                   P_MEM_WB = 4, P_MEM_WRITE = 5, P_EXEC_R = 6, P_EXEC_I = 7,
                   P_ALU_WB = 8, P_BEQ = 9, P_JAL = 10;

    localparam logic [6:0] C_LOAD = 7'b0000011, C_STORE = 7'b0100011,
                           C_REG  = 7'b0110011, C_IMM   = 7'b0010011,
                           C_BR   = 7'b1100011, C_JAL   = 7'b1101111,
                           C_LUI  = 7'b0110111;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [6:0]     opcode;
    logic           zero;
    logic           mem_ready;
    logic           mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]     result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic           illegal;
    logic [C_W-1:0] instret;
    logic [3:0]     state;

    multicycle_controller #(.INSTRET_W(C_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
        .illegal(illegal), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         st;
        logic [6:0] opc;
        bit         rdy, z, mreq, mwr, adr, irw, pcw, rw, ill, ret;
        logic [1:0] res, a, b, op, imm;
    } cyc_t;

    typedef struct {
        logic [6:0] opc;
        bit         z;
        int         fst, mst, cyc, pcw, rw, ill, ret, imm;
    } vec_t;

    cyc_t       cq[$];
    vec_t       tbl[10];
    int         checks = 0;
    int         failures = 0;
    int         model_ir = 0;
    logic [6:0] prev_opc = 7'd0;
    int         m_pcw, m_rw, m_irw, m_ill, m_imm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        if (op == C_STORE) return 2'b01;
        if (op == C_BR)    return 2'b10;
        if (op == C_JAL)   return 2'b11;
        return 2'b00;
    endfunction

    // Append one expected cycle: outputs follow directly from the state's row
    // in the control table plus the retire rule.
    task automatic add_cyc(input int st, input logic [6:0] opc, input bit rdy, input bit z);
        cyc_t c;
        c = '{st: st, opc: opc, rdy: rdy, z: z, default: '0};
        c.imm = imm_of(opc);
        case (st)
            P_FETCH:     begin c.mreq = 1; c.b = 2; c.res = 2; c.irw = rdy; c.pcw = rdy; end
            P_DECODE:    begin c.a = 1; c.b = 1;
                               c.ill = !(opc inside {C_LOAD, C_STORE, C_REG, C_IMM, C_BR, C_JAL}); end
            P_MEM_ADR:   begin c.a = 2; c.b = 1; end
            P_MEM_READ:  begin c.mreq = 1; c.adr = 1; end
            P_MEM_WB:    begin c.res = 1; c.rw = 1; end
            P_MEM_WRITE: begin c.mreq = 1; c.mwr = 1; c.adr = 1; end
            P_EXEC_R:    begin c.a = 2; c.b = 0; c.op = 2; end
            P_EXEC_I:    begin c.a = 2; c.b = 1; c.op = 2; end
            P_ALU_WB:    begin c.res = 0; c.rw = 1; end
            P_JAL:       begin c.a = 1; c.b = 2; c.res = 0; c.pcw = 1; end
            P_BEQ:       begin c.a = 2; c.b = 0; c.op = 1; c.res = 0; c.pcw = z; end
            default: ;
        endcase
        c.ret = (st == P_MEM_WB) || (st == P_ALU_WB) || (st == P_BEQ) ||
                (st == P_MEM_WRITE && rdy);
        cq.push_back(c);
    endtask

    // Phase sequence of one instruction with the given memory stall counts
    task automatic plan(input logic [6:0] opc, input bit z, input int fst, input int mst);
        cq.delete();
        for (int i = 0; i < fst; i++) add_cyc(P_FETCH, prev_opc, 1'b0, z);
        add_cyc(P_FETCH, prev_opc, 1'b1, z);
        add_cyc(P_DECODE, opc, 1'($urandom), z);
        case (opc)
            C_LOAD: begin
                add_cyc(P_MEM_ADR, opc, 1'($urandom), z);
                for (int i = 0; i < mst; i++) add_cyc(P_MEM_READ, opc, 1'b0, z);
                add_cyc(P_MEM_READ, opc, 1'b1, z);
                add_cyc(P_MEM_WB, opc, 1'($urandom), z);
            end
            C_STORE: begin
                add_cyc(P_MEM_ADR, opc, 1'($urandom), z);
                for (int i = 0; i < mst; i++) add_cyc(P_MEM_WRITE, opc, 1'b0, z);
                add_cyc(P_MEM_WRITE, opc, 1'b1, z);
            end
            C_REG: begin
                add_cyc(P_EXEC_R, opc, 1'($urandom), z);
                add_cyc(P_ALU_WB, opc, 1'($urandom), z);
            end
            C_IMM: begin
                add_cyc(P_EXEC_I, opc, 1'($urandom), z);
                add_cyc(P_ALU_WB, opc, 1'($urandom), z);
            end
            C_BR:  add_cyc(P_BEQ, opc, 1'($urandom), z);
            C_JAL: begin
                add_cyc(P_JAL, opc, 1'($urandom), z);
                add_cyc(P_ALU_WB, opc, 1'($urandom), z);
            end
            default: ;
        endcase
        prev_opc = opc;
    endtask

    task automatic run_plan(input int limit);
        logic [31:0] ev, av;
        m_pcw = 0; m_rw = 0; m_irw = 0; m_ill = 0; m_imm = -1;
        for (int i = 0; i < cq.size() && i < limit; i++) begin
            @(negedge clk);
            opcode    = cq[i].opc;
            mem_ready = cq[i].rdy;
            zero      = cq[i].z;
            #1;
            ev = 32'({4'(cq[i].st), cq[i].mreq, cq[i].mwr, cq[i].adr, cq[i].irw,
                      cq[i].pcw, cq[i].rw, cq[i].res, cq[i].a, cq[i].b,
                      cq[i].op, cq[i].imm, cq[i].ill});
            av = 32'({state, mem_req, mem_write, adr_src, ir_write, pc_write,
                      reg_write, result_src, alu_src_a, alu_src_b, alu_op,
                      imm_src, illegal});
            chk($sformatf("outputs opc=%b cyc%0d st%0d", cq[i].opc, i, cq[i].st), av, ev);
            chk("instret", 32'(instret), 32'(model_ir));
            m_pcw += int'(pc_write);
            m_rw  += int'(reg_write);
            m_irw += int'(ir_write);
            m_ill += int'(illegal);
            if (cq[i].st == P_DECODE) m_imm = int'(imm_src);
            if (cq[i].ret) model_ir = (model_ir + 1) % (1 << C_W);
        end
    endtask

    initial begin
        logic [6:0] ops[10];
        int         ir0, ir1;

        //            opc      z  fst mst cyc pcw rw ill ret imm
        tbl[0] = '{C_REG,   0, 0, 0, 4, 1, 1, 0, 1, 0};
        tbl[1] = '{C_LOAD,  0, 2, 1, 8, 1, 1, 0, 1, 0};
        tbl[2] = '{C_STORE, 0, 0, 0, 4, 1, 0, 0, 1, 1};
        tbl[3] = '{C_STORE, 1, 1, 2, 7, 1, 0, 0, 1, 1};
        tbl[4] = '{C_BR,    1, 0, 0, 3, 2, 0, 0, 1, 2};
        tbl[5] = '{C_BR,    0, 0, 0, 3, 1, 0, 0, 1, 2};
        tbl[6] = '{C_JAL,   0, 0, 0, 4, 2, 1, 0, 1, 3};
        tbl[7] = '{C_LUI,   0, 0, 0, 2, 1, 0, 1, 0, 0};
        tbl[8] = '{C_IMM,   0, 1, 0, 5, 1, 1, 0, 1, 0};
        tbl[9] = '{C_LOAD,  0, 0, 0, 5, 1, 1, 0, 1, 0};

        // Reset state, with mem_ready high to expose any ungated strobe
        rst_n = 1'b0; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b1;
        #12;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_instret", 32'(instret), 32'd0);
        chk("reset_strobes", 32'({mem_req, ir_write, pc_write, mem_write, reg_write, illegal}), 32'd0);
        chk("reset_selects", 32'({result_src, alu_src_a, alu_src_b, alu_op, adr_src}), 32'b10_00_10_00_0);
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0;
        #1;
        chk("first_fetch_req", 32'(mem_req), 32'd1);

        // Table vectors
        foreach (tbl[k]) begin
            plan(tbl[k].opc, tbl[k].z, tbl[k].fst, tbl[k].mst);
            chk($sformatf("vec%0d cycles", k), 32'(cq.size()), 32'(tbl[k].cyc));
            ir0 = int'(instret);
            run_plan(1000);
            @(posedge clk); #1;
            ir1 = int'(instret);
            chk($sformatf("vec%0d pc_write_count", k), 32'(m_pcw), 32'(tbl[k].pcw));
            chk($sformatf("vec%0d reg_write_count", k), 32'(m_rw), 32'(tbl[k].rw));
            chk($sformatf("vec%0d ir_write_count", k), 32'(m_irw), 32'd1);
            chk($sformatf("vec%0d illegal_count", k), 32'(m_ill), 32'(tbl[k].ill));
            chk($sformatf("vec%0d imm_src", k), 32'(m_imm), 32'(tbl[k].imm));
            chk($sformatf("vec%0d instret_delta", k), 32'((ir1 - ir0) & ((1 << C_W) - 1)), 32'(tbl[k].ret));
        end

        // Random instruction stream
        ops = '{C_LOAD, C_STORE, C_REG, C_IMM, C_BR, C_JAL, C_LUI,
                7'b0010111, 7'b1100111, 7'b0000000};
        for (int n = 0; n < 80; n++) begin
            plan(ops[$urandom_range(9)], 1'($urandom), $urandom_range(3), $urandom_range(3));
            run_plan(1000);
        end

        // Reset while a store is stalled in MEM_WRITE
        plan(C_STORE, 1'b0, 0, 5);
        run_plan(4);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_mem_write", 32'(mem_write), 32'd0);
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_instret", 32'(instret), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_refetch", 32'({state, mem_req}), 32'd1);
        model_ir = 0;

        // Counter wrap: 16 retirements on a 4-bit counter
        for (int n = 0; n < 16; n++) begin
            plan(C_REG, 1'b0, 0, 0);
            run_plan(1000);
            @(posedge clk); #1;
            if (n == 14) chk("wrap_max", 32'(instret), 32'd15);
            if (n == 15) chk("wrap_zero", 32'(instret), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
